// File: rtl/reg_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_reader_pkg
// Description : Shared constants and helpers for the register dump reader:
//               FSM state encoding and byte-count derivation.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_dump_reader_pkg;

   // FSM state encoding shared by the top-level controller
   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_LOAD = 2'd1;
   localparam logic [1:0] c_ST_SEND = 2'd2;
   localparam logic [1:0] c_ST_DONE = 2'd3;

   // Number of bytes streamed per register
   function automatic int unsigned bytes_of(input int unsigned width);
      return width / 8;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned count_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/reg_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_reader_if
// Description : Bundles the register-file read port and the outgoing byte
//               stream of the dump reader. The master side is the reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_dump_reader_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   logic [AW-1:0]    rd_addr;
   logic [WIDTH-1:0] rd_data;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_last;

   modport master (
      output rd_addr,
      input  rd_data,
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  rd_addr,
      output rd_data,
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );
endinterface
`default_nettype wire

// File: rtl/reg_dump_reader_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : byte_serializer
// Description : Parallel-load shift register that presents a word MSB byte
//               first, advancing one byte per accepted handshake, with a
//               flag marking the final byte of the word.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_serializer
   import reg_dump_reader_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             accept,
   output logic [7:0]       byte_out,
   output logic             last_byte
);

   localparam int BYTES = bytes_of(WIDTH);
   localparam int CW    = count_width(BYTES);
   localparam logic [CW-1:0] c_LAST_IDX = CW'(BYTES - 1);

   logic [WIDTH-1:0] r_shift;
   logic [CW-1:0]    r_count;
   logic             w_last;

   // Last byte of the word is reached once the counter hits BYTES-1; the
   // final accept leaves the shift register untouched so the byte stays put
   assign w_last = (r_count == c_LAST_IDX);

   // Word capture on load, one-byte advance on each accepted non-final byte
   always_ff @(posedge clock) begin
      if (reset) begin
         r_shift <= '0;
         r_count <= '0;
      end else if (load) begin
         r_shift <= load_data;
         r_count <= '0;
      end else if (accept && !w_last) begin
         r_shift <= r_shift << 8;
         r_count <= r_count + CW'(1);
      end
   end

   assign byte_out  = r_shift[WIDTH-1 -: 8];
   assign last_byte = w_last;

endmodule
`default_nettype wire

// File: rtl/reg_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : reg_dump_reader
// Description : Debug read-out engine. On start, walks the register file
//               from address 0 to NREGS-1, snapshots each register in a
//               dedicated LOAD cycle and streams it out MSB byte first over
//               a valid/ready byte interface.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_dump_reader
   import reg_dump_reader_pkg::*;
#(
   parameter int NREGS = 32,
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   reg_dump_reader_if.master  bus,
   output logic               busy,
   output logic               done
);

   localparam logic [AW-1:0] c_LAST_ADDR = AW'(NREGS - 1);

   logic [1:0]    r_state;
   logic [1:0]    w_state_nxt;
   logic [AW-1:0] r_addr;
   logic [AW-1:0] w_addr_nxt;

   logic          w_load;
   logic          w_send;
   logic          w_accept;
   logic          w_last_byte;
   logic          w_last_reg;
   logic [7:0]    w_byte;

   assign w_load     = (r_state == c_ST_LOAD);
   assign w_send     = (r_state == c_ST_SEND);
   assign w_accept   = w_send && bus.out_ready;
   assign w_last_reg = (r_addr == c_LAST_ADDR);

   // Shift register and byte counter for the register currently streaming
   byte_serializer #(
      .WIDTH     (WIDTH)
   ) u_byte_serializer (
      .clock     (clock),
      .reset     (reset),
      .load      (w_load),
      .load_data (bus.rd_data),
      .accept    (w_accept),
      .byte_out  (w_byte),
      .last_byte (w_last_byte)
   );

   // Next-state and next-address decode for the dump walk
   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      case (r_state)
         c_ST_IDLE: begin
            if (start) begin
               w_state_nxt = c_ST_LOAD;
            end
         end
         c_ST_LOAD: begin
            w_state_nxt = c_ST_SEND;
         end
         c_ST_SEND: begin
            // Only the accepted final byte of a register moves the walk on
            if (w_accept && w_last_byte) begin
               if (w_last_reg) begin
                  w_state_nxt = c_ST_DONE;
               end else begin
                  w_addr_nxt  = r_addr + AW'(1);
                  w_state_nxt = c_ST_LOAD;
               end
            end
         end
         c_ST_DONE: begin
            w_addr_nxt  = '0;
            w_state_nxt = c_ST_IDLE;
         end
         default: begin
            w_addr_nxt  = '0;
            w_state_nxt = c_ST_IDLE;
         end
      endcase
   end

   // State and address registers; reset abandons any dump in flight
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= c_ST_IDLE;
         r_addr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
      end
   end

   // All outputs decode registered state; out_ready never reaches an output
   assign bus.rd_addr   = r_addr;
   assign bus.out_data  = w_byte;
   assign bus.out_valid = w_send;
   assign bus.out_last  = w_send && w_last_reg && w_last_byte;
   assign busy          = (r_state != c_ST_IDLE);
   assign done          = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
